// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    HOLD,
    ADVANCE,
    DRAIN,
    FAULT
  } fetch_state_e;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_MEMERR   = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

  // Decode substitutes this (addi x0,x0,0) whenever instr_valid is low.
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  function automatic int unsigned timer_width(input int unsigned max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Saturating cycle timer that bounds how long a memory request may stay outstanding.
module fetch_watchdog
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = timer_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  // Fires in the cycle whose increment makes the count reach the limit.
  assign expired = enable && (count >= LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches one instruction per PC value over a req/rvalid memory port and hands it
// to decode over valid/ready, pulsing pc_advance after each accepted instruction.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W         = 64,
  parameter int unsigned INSTR_W        = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               fetch_en,
  input  logic               flush,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_err,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  output logic               pc_advance,
  output logic               fault,
  output logic [1:0]         fault_cause
);

  fetch_state_e state;

  logic pc_aligned;
  logic tmr_clear;
  logic tmr_en;
  logic tmr_expired;

  assign pc_aligned = (pc_in[1:0] == 2'b00);

  // Restart the timer when a request is launched and again when a flush
  // turns the outstanding request into a drain.
  always_comb begin
    tmr_clear = 1'b0;
    if ((state == IDLE) && !flush && fetch_en && pc_aligned) begin
      tmr_clear = 1'b1;
    end
    if ((state == WAIT) && flush && !imem_rvalid) begin
      tmr_clear = 1'b1;
    end
  end

  assign tmr_en = (state == WAIT) || (state == DRAIN);

  fetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      pc_advance  <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= FC_NONE;
    end else begin
      pc_advance <= 1'b0;
      // Flush outranks everything; only WAIT and DRAIN must account for a live request.
      if (flush && (state != WAIT) && (state != DRAIN)) begin
        state       <= IDLE;
        imem_req    <= 1'b0;
        instr_valid <= 1'b0;
        fault       <= 1'b0;
        fault_cause <= FC_NONE;
      end else begin
        case (state)
          IDLE: begin
            if (fetch_en) begin
              if (!pc_aligned) begin
                state       <= FAULT;
                fault       <= 1'b1;
                fault_cause <= FC_MISALIGN;
              end else begin
                imem_addr <= pc_in;
                imem_req  <= 1'b1;
                state     <= WAIT;
              end
            end
          end
          WAIT: begin
            if (flush) begin
              imem_req <= 1'b0;
              state    <= imem_rvalid ? IDLE : DRAIN;
            end else if (imem_rvalid) begin
              imem_req <= 1'b0;
              if (imem_err) begin
                state       <= FAULT;
                fault       <= 1'b1;
                fault_cause <= FC_MEMERR;
              end else begin
                instr       <= imem_rdata;
                instr_pc    <= imem_addr;
                instr_valid <= 1'b1;
                state       <= HOLD;
              end
            end else if (tmr_expired) begin
              imem_req    <= 1'b0;
              state       <= FAULT;
              fault       <= 1'b1;
              fault_cause <= FC_TIMEOUT;
            end
          end
          HOLD: begin
            if (instr_ready) begin
              instr_valid <= 1'b0;
              pc_advance  <= 1'b1;
              state       <= ADVANCE;
            end
          end
          ADVANCE: begin
            state <= IDLE;
          end
          DRAIN: begin
            // A silent memory cannot be blamed for a request we cancelled.
            if (imem_rvalid || tmr_expired) begin
              state <= IDLE;
            end
          end
          FAULT: begin
            state <= FAULT;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded bench for instr_fetch_unit: a behavioural memory pushes expected
// instructions as it responds; a decode-side monitor pops them on each handshake.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned TO_MAIN  = 16;
  localparam int unsigned TO_SHORT = 4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [ADDR_W-1:0]  pc_in;
  logic               fetch_en;
  logic               flush;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rvalid = 1'b0;
  logic [INSTR_W-1:0] imem_rdata  = '0;
  logic               imem_err    = 1'b0;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;
  logic               pc_advance;
  logic               fault;
  logic [1:0]         fault_cause;

  logic               t_reset;
  logic               t_fetch_en;
  logic               t_req;
  logic [ADDR_W-1:0]  t_addr;
  logic               t_valid;
  logic [INSTR_W-1:0] t_instr;
  logic [ADDR_W-1:0]  t_pc;
  logic               t_adv;
  logic               t_fault;
  logic [1:0]         t_cause;

  instr_fetch_unit #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .TIMEOUT_CYCLES(TO_MAIN)
  ) u_dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .fetch_en(fetch_en), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .imem_err(imem_err), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .pc_advance(pc_advance), .fault(fault), .fault_cause(fault_cause)
  );

  instr_fetch_unit #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .TIMEOUT_CYCLES(TO_SHORT)
  ) u_dut_to (
    .clk(clk), .reset(t_reset), .pc_in(64'h100), .fetch_en(t_fetch_en), .flush(1'b0),
    .imem_req(t_req), .imem_addr(t_addr), .imem_rvalid(1'b0),
    .imem_rdata(32'h0), .imem_err(1'b0), .instr_valid(t_valid),
    .instr(t_instr), .instr_pc(t_pc), .instr_ready(1'b0),
    .pc_advance(t_adv), .fault(t_fault), .fault_cause(t_cause)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'h0050_0093 ^ a[31:0];
  endfunction

  exp_t exp_q[$];

  // Behavioural memory: responds mem_lat cycles after the request first appears,
  // even if the request has since been withdrawn by a flush.
  int unsigned       mem_lat    = 0;
  bit                mem_silent = 1'b0;
  bit                mem_err_en = 1'b0;
  bit                drop_resp  = 1'b0;
  bit                pending    = 1'b0;
  int unsigned       wcnt       = 0;
  logic [ADDR_W-1:0] paddr      = '0;

  always begin
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_err    = 1'b0;
    if (!reset) begin
      pending = 1'b0;
    end else begin
      if (!pending && imem_req && !mem_silent) begin
        pending = 1'b1;
        wcnt    = 0;
        paddr   = imem_addr;
      end
      if (pending) begin
        if (wcnt == mem_lat) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
          imem_err    = mem_err_en;
          pending     = 1'b0;
          if (!mem_err_en && !drop_resp) exp_q.push_back('{instr: mem_word(paddr), pc: paddr});
        end else begin
          wcnt++;
        end
      end
    end
  end

  exp_t        mon_e;
  int unsigned adv_cnt = 0;
  logic [INSTR_W-1:0] decode_word;
  assign decode_word = instr_valid ? instr : INSTR_NOP;

  always @(negedge clk) begin
    if (reset && instr_valid && instr_ready) begin
      check("sb_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("sb_instr", 64'(instr), 64'(mon_e.instr));
        check("sb_pc", instr_pc, mon_e.pc);
      end
    end
    if (pc_advance) adv_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  int unsigned adv0;

  initial begin
    reset = 1'b0; t_reset = 1'b0;
    pc_in = '0; fetch_en = 1'b0; flush = 1'b0; instr_ready = 1'b0; t_fetch_en = 1'b0;
    repeat (2) step();

    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_addr", imem_addr, 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_pc", instr_pc, 64'd0);
    check("rst_adv", 64'(pc_advance), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_cause", 64'(fault_cause), 64'd0);
    check("rst_decode_nop", 64'(decode_word), 64'h13);
    check("rst_t_all", 64'({t_req, t_valid, t_adv, t_fault, t_cause}), 64'd0);
    check("rst_t_data", t_addr | t_pc | 64'(t_instr), 64'd0);
    reset = 1'b1; t_reset = 1'b1;
    step();

    // Zero-wait memory, decode always ready.
    adv0 = adv_cnt;
    pc_in = 64'h0; fetch_en = 1'b1; instr_ready = 1'b1; mem_lat = 0;
    step();
    fetch_en = 1'b0;
    check("t1_req_c1", 64'(imem_req), 64'd1);
    check("t1_addr_c1", imem_addr, 64'h0);
    check("t1_valid_c1", 64'(instr_valid), 64'd0);
    step();
    check("t1_valid_c2", 64'(instr_valid), 64'd1);
    check("t1_instr_c2", 64'(instr), 64'h0050_0093);
    check("t1_pc_c2", instr_pc, 64'h0);
    check("t1_req_c2", 64'(imem_req), 64'd0);
    check("t1_adv_c2", 64'(pc_advance), 64'd0);
    step();
    check("t1_adv_c3", 64'(pc_advance), 64'd1);
    check("t1_valid_c3", 64'(instr_valid), 64'd0);
    step();
    check("t1_adv_c4", 64'(pc_advance), 64'd0);
    check("t1_adv_count", 64'(adv_cnt - adv0), 64'd1);

    // Five-cycle memory latency, decode stalls three cycles.
    adv0 = adv_cnt;
    pc_in = 64'h40; fetch_en = 1'b1; instr_ready = 1'b0; mem_lat = 4;
    step();
    fetch_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t2_req", 64'(imem_req), 64'd1);
      check("t2_addr", imem_addr, 64'h40);
      check("t2_valid_wait", 64'(instr_valid), 64'd0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_valid", 64'(instr_valid), 64'd1);
      check("t2_hold_instr", 64'(instr), 64'(mem_word(64'h40)));
      check("t2_hold_pc", instr_pc, 64'h40);
      check("t2_hold_adv", 64'(pc_advance), 64'd0);
      step();
    end
    check("t2_valid_c9", 64'(instr_valid), 64'd1);
    instr_ready = 1'b1;
    step();
    check("t2_adv_c10", 64'(pc_advance), 64'd1);
    check("t2_valid_c10", 64'(instr_valid), 64'd0);
    step();
    check("t2_adv_c11", 64'(pc_advance), 64'd0);
    check("t2_adv_count", 64'(adv_cnt - adv0), 64'd1);

    // Misaligned PC faults without a request; fetch_en is ignored until flush.
    pc_in = 64'h6; fetch_en = 1'b1;
    step();
    check("t3_req", 64'(imem_req), 64'd0);
    check("t3_fault", 64'(fault), 64'd1);
    check("t3_cause", 64'(fault_cause), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_sticky_fault", 64'(fault), 64'd1);
      check("t3_sticky_cause", 64'(fault_cause), 64'd1);
      check("t3_sticky_req", 64'(imem_req), 64'd0);
    end
    flush = 1'b1; fetch_en = 1'b0;
    step();
    flush = 1'b0;
    check("t3_flush_fault", 64'(fault), 64'd0);
    check("t3_flush_cause", 64'(fault_cause), 64'd0);

    // Memory error response.
    pc_in = 64'h80; fetch_en = 1'b1; mem_err_en = 1'b1; mem_lat = 1;
    step();
    fetch_en = 1'b0;
    check("t4_req_c1", 64'(imem_req), 64'd1);
    step();
    check("t4_req_c2", 64'(imem_req), 64'd1);
    step();
    check("t4_req_c3", 64'(imem_req), 64'd0);
    check("t4_fault", 64'(fault), 64'd1);
    check("t4_cause", 64'(fault_cause), 64'd2);
    check("t4_valid", 64'(instr_valid), 64'd0);
    mem_err_en = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t4_flush_fault", 64'(fault), 64'd0);

    // Flush mid-WAIT: drain the late response, ignore a second flush, refetch.
    pc_in = 64'h100; fetch_en = 1'b1; mem_lat = 4; drop_resp = 1'b1; instr_ready = 1'b1;
    step();
    check("t5_req_c1", 64'(imem_req), 64'd1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; pc_in = 64'h200;
    check("t5_req_c3", 64'(imem_req), 64'd0);
    check("t5_valid_c3", 64'(instr_valid), 64'd0);
    step();
    flush = 1'b1;
    check("t5_req_c4", 64'(imem_req), 64'd0);
    check("t5_valid_c4", 64'(instr_valid), 64'd0);
    step();
    flush = 1'b0;
    check("t5_req_c5", 64'(imem_req), 64'd0);
    check("t5_valid_c5", 64'(instr_valid), 64'd0);
    step();
    check("t5_req_c6", 64'(imem_req), 64'd0);
    check("t5_valid_c6", 64'(instr_valid), 64'd0);
    drop_resp = 1'b0; mem_lat = 0;
    step();
    fetch_en = 1'b0;
    check("t5_req_c7", 64'(imem_req), 64'd1);
    check("t5_addr_c7", imem_addr, 64'h200);
    step();
    check("t5_valid_c8", 64'(instr_valid), 64'd1);
    step();
    check("t5_adv_c9", 64'(pc_advance), 64'd1);
    step();

    // Asynchronous reset between edges while waiting on a silent memory.
    pc_in = 64'h300; fetch_en = 1'b1; mem_silent = 1'b1;
    step();
    fetch_en = 1'b0;
    check("t6_req_c1", 64'(imem_req), 64'd1);
    step();
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_req", 64'(imem_req), 64'd0);
    check("t6_async_valid", 64'(instr_valid), 64'd0);
    check("t6_async_fault", 64'(fault), 64'd0);
    check("t6_async_addr", imem_addr, 64'd0);
    step();
    step();
    reset = 1'b1; mem_silent = 1'b0;
    step();

    // Timeout on the short-timeout instance; its memory never answers.
    t_fetch_en = 1'b1;
    step();
    t_fetch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t7_req", 64'(t_req), 64'd1);
      check("t7_addr", t_addr, 64'h100);
      check("t7_fault_wait", 64'(t_fault), 64'd0);
      step();
    end
    check("t7_req_after", 64'(t_req), 64'd0);
    check("t7_fault", 64'(t_fault), 64'd1);
    check("t7_cause", 64'(t_cause), 64'd3);
    step();
    check("t7_sticky_cause", 64'(t_cause), 64'd3);
    check("t7_no_instr", 64'({t_valid, t_adv}), 64'd0);
    check("t7_quiet_data", t_pc | 64'(t_instr), 64'd0);

    check("sb_empty_at_end", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
